// File: rtl/approx_mul_pkg.sv
// Shared constants and helpers for the approximate multiplier arbiter.
// Optional feature macro used by the top: APPROX_MUL_EXACT_EN.
package approx_mul_pkg;

  localparam int OP_W    = 32;  // operand width
  localparam int PROD_W  = 64;  // product width
  localparam int WIN_MAX = 8;   // window width when a top nibble is set
  localparam int WIN_MID = 7;   // window width when the second nibble is set
  localparam int WIN_MIN = 6;   // window width for small operands
  localparam int NIB_HI  = 28;  // low bit of the top nibble
  localparam int NIB_MID = 24;  // low bit of the second nibble
  localparam int LO_W    = 5;   // width of a leading-one index
  localparam int SHIFT_W = 6;   // width of the total shift (max 48)

  // Index of the most significant set bit; 0 for a zero operand.
  function automatic logic [LO_W-1:0] lead_one(input logic [OP_W-1:0] x);
    lead_one = '0;
    for (int i = 0; i < OP_W; i++) begin
      if (x[i]) lead_one = LO_W'(i);
    end
  endfunction

endpackage

// File: rtl/approx_mul_window.sv
// Combinational front end: picks the shared window width from the upper
// nibbles of both operands, then keeps the leading `num` bits of each
// operand and reports how far the product must be shifted back.
module approx_mul_window
  import approx_mul_pkg::*;
(
  input  logic [OP_W-1:0]    a,
  input  logic [OP_W-1:0]    b,
  output logic [WIN_MAX-1:0] m,
  output logic [WIN_MAX-1:0] n,
  output logic [SHIFT_W-1:0] s
);

  logic [LO_W-1:0] num;
  logic [LO_W-1:0] k;
  logic [LO_W-1:0] l;
  logic [LO_W-1:0] sa;
  logic [LO_W-1:0] sb;

  // Window width, leading-one positions, windowed operands and total shift.
  always_comb begin
    num = LO_W'(WIN_MIN);
    if ((|a[OP_W-1:NIB_HI]) || (|b[OP_W-1:NIB_HI])) begin
      num = LO_W'(WIN_MAX);
    end else if ((|a[NIB_HI-1:NIB_MID]) || (|b[NIB_HI-1:NIB_MID])) begin
      num = LO_W'(WIN_MID);
    end
    k  = lead_one(a);
    l  = lead_one(b);
    // An operand already narrower than the window is kept whole.
    sa = (k < num) ? '0 : (k - num + LO_W'(1));
    sb = (l < num) ? '0 : (l - num + LO_W'(1));
    // After the shift the leading one sits at bit num-1, so it fits the window.
    m  = WIN_MAX'(a >> sa);
    n  = WIN_MAX'(b >> sb);
    s  = SHIFT_W'(sa) + SHIFT_W'(sb);
  end

endmodule

// File: rtl/approx_mul_arbiter.sv
// Round-robin arbiter in front of a 2-stage approximate 32x32 multiplier.
// S1 holds the windowed operands, S2 the product. Define
// APPROX_MUL_EXACT_EN to add req_exact, which bypasses the windowing.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready, and out_y/out_id hold while
// out_valid && !out_ready.
module approx_mul_arbiter
  import approx_mul_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int PIPE_ID_W = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*OP_W-1:0] req_a,
  input  logic [NUM_REQ*OP_W-1:0] req_b,
`ifdef APPROX_MUL_EXACT_EN
  input  logic [NUM_REQ-1:0]      req_exact,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PROD_W-1:0]       out_y,
  output logic [PIPE_ID_W-1:0]    out_id
);

  logic [PIPE_ID_W-1:0] rr_ptr;
  logic [PIPE_ID_W-1:0] gnt_id;
  logic [PIPE_ID_W-1:0] cand;
  logic [PIPE_ID_W:0]   idx;
  logic                 gnt_found;
  logic                 s2_adv;
  logic                 s1_acc;
  logic                 xfer;
  logic [OP_W-1:0]      sel_a;
  logic [OP_W-1:0]      sel_b;
  logic [WIN_MAX-1:0]   win_m;
  logic [WIN_MAX-1:0]   win_n;
  logic [SHIFT_W-1:0]   win_s;
  logic [OP_W-1:0]      ld_m;
  logic [OP_W-1:0]      ld_n;
  logic [SHIFT_W-1:0]   ld_s;
  logic                 s1_valid;
  logic [OP_W-1:0]      s1_m;
  logic [OP_W-1:0]      s1_n;
  logic [SHIFT_W-1:0]   s1_s;
  logic [PIPE_ID_W-1:0] s1_id;
  logic [PROD_W-1:0]    prod;

  // Round-robin search: first valid requester starting at rr_ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    cand      = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      idx = {1'b0, rr_ptr} + (PIPE_ID_W+1)'(j);
      if (idx >= (PIPE_ID_W+1)'(NUM_REQ)) idx = idx - (PIPE_ID_W+1)'(NUM_REQ);
      cand = idx[PIPE_ID_W-1:0];
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  // Stall chain and the single one-hot ready; ready is forced low in reset.
  always_comb begin
    s2_adv    = !out_valid || out_ready;
    s1_acc    = !s1_valid || s2_adv;
    req_ready = '0;
    if (rst_n && gnt_found && s1_acc) req_ready = NUM_REQ'(1) << gnt_id;
    xfer      = |(req_valid & req_ready);
    sel_a     = req_a[int'(gnt_id)*OP_W +: OP_W];
    sel_b     = req_b[int'(gnt_id)*OP_W +: OP_W];
  end

  approx_mul_window u_window (
    .a (sel_a),
    .b (sel_b),
    .m (win_m),
    .n (win_n),
    .s (win_s)
  );

  // Operands loaded into S1: windowed, or the raw operands for exact requests.
  always_comb begin
    ld_m = OP_W'(win_m);
    ld_n = OP_W'(win_n);
    ld_s = win_s;
`ifdef APPROX_MUL_EXACT_EN
    if (req_exact[gnt_id]) begin
      ld_m = sel_a;
      ld_n = sel_b;
      ld_s = '0;
    end
`endif
  end

  // S1 register and round-robin pointer; pointer moves only on a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_m     <= '0;
      s1_n     <= '0;
      s1_s     <= '0;
      s1_id    <= '0;
      rr_ptr   <= '0;
    end else if (s1_acc) begin
      s1_valid <= xfer;
      if (xfer) begin
        s1_m   <= ld_m;
        s1_n   <= ld_n;
        s1_s   <= ld_s;
        s1_id  <= gnt_id;
        rr_ptr <= (gnt_id == PIPE_ID_W'(NUM_REQ-1)) ? '0 : gnt_id + PIPE_ID_W'(1);
      end
    end
  end

  // Multiply and shift back into the original magnitude.
  always_comb begin
    prod = (PROD_W'(s1_m) * PROD_W'(s1_n)) << s1_s;
  end

  // S2 result register; holds its contents while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_id    <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_y  <= prod;
        out_id <= s1_id;
      end
    end
  end

endmodule

// File: tb/tb_approx_mul_arbiter.sv
// Directed bench for approx_mul_arbiter: latency, round-robin order,
// back-pressure, reset flush and (when built with APPROX_MUL_EXACT_EN)
// the exact-product bypass. Expected products are hand-computed.
module tb_approx_mul_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*32-1:0]   req_a;
  logic [NUM_REQ*32-1:0]   req_b;
`ifdef APPROX_MUL_EXACT_EN
  logic [NUM_REQ-1:0]      req_exact;
`endif
  logic                    out_valid;
  logic                    out_ready;
  logic [63:0]             out_y;
  logic [ID_W-1:0]         out_id;

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  int n_exp = 0;
  logic [71:0] exp_q[$];
  logic [63:0] y_tab[NUM_REQ];

  approx_mul_arbiter #(.NUM_REQ(NUM_REQ), .PIPE_ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
`ifdef APPROX_MUL_EXACT_EN
    .req_exact (req_exact),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_id    (out_id)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b);
    req_a[id*32 +: 32] = a;
    req_b[id*32 +: 32] = b;
  endtask

  task automatic expect_res(input int id, input logic [63:0] y);
    exp_q.push_back({8'(id), y});
    n_exp++;
  endtask

  // Single request from one requester; ready must be that requester alone.
  task automatic issue_one(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] y);
    set_req(id, a, b);
    req_valid = 4'(1 << id);
    #1;
    check("single_ready", 64'(req_ready), 64'(1 << id));
    expect_res(id, y);
    tick();
    req_valid = '0;
  endtask

  // scoreboard: pop one expected entry per accepted result
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("extra_result", 64'(exp_q.size()), 64'd1);
      end else begin
        logic [71:0] e;
        e = exp_q.pop_front();
        check("out_y", out_y, e[63:0]);
        check("out_id", 64'(out_id), 64'(e[71:64]));
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    out_ready = 1'b1;
`ifdef APPROX_MUL_EXACT_EN
    req_exact = '0;
`endif
    idle(2);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_y", out_y, 64'd0);
    req_valid = '0;
    rst_n = 1'b1;
    #1;
    check("idle_ready", 64'(req_ready), 64'd0);

    // latency: 0xFF*3 -> window 63*3 << 2 = 756, result two edges later
    issue_one(0, 32'h0000_00FF, 32'h0000_0003, 64'd756);
    check("lat1_valid", 64'(out_valid), 64'd0);
    tick();
    check("lat2_valid", 64'(out_valid), 64'd1);
    check("lat2_y", out_y, 64'd756);
    idle(2);

    // top-nibble window: 0x80 * 2 << 24 = 2^32
    issue_one(1, 32'h8000_0001, 32'h0000_0002, 64'h0000_0001_0000_0000);
    idle(3);
    // second-nibble window: 0x78 << 21 = 0x0F000000
    issue_one(2, 32'h0F00_0000, 32'h0000_0001, 64'h0000_0000_0F00_0000);
    // k=5 kept whole, l=6 shifted by 1: 63*32 << 1 = 4032
    issue_one(3, 32'h0000_003F, 32'h0000_0040, 64'd4032);
    idle(3);

    // round robin with all four valid, one result per cycle
    set_req(0, 32'h0000_00FF, 32'h0000_0003); y_tab[0] = 64'd756;
    set_req(1, 32'h8000_0001, 32'h0000_0002); y_tab[1] = 64'h0000_0001_0000_0000;
    set_req(2, 32'h0000_0010, 32'h0000_0010); y_tab[2] = 64'd256;
    set_req(3, 32'h0000_0000, 32'h0000_1234); y_tab[3] = 64'd0;
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      #1;
      check("rr_ready", 64'(req_ready), 64'(1 << (c % 4)));
      expect_res(c % 4, y_tab[c % 4]);
      tick();
      if (c >= 1) check("rr_stream", 64'(out_valid), 64'd1);
    end
    req_valid = '0;
    tick();
    check("rr_last", 64'(out_valid), 64'd1);
    tick();
    check("rr_drained", 64'(out_valid), 64'd0);

    // back-pressure with the pipe full
    set_req(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    out_ready = 1'b0;
    req_valid = 4'b0111;
    #1;
    check("bp_ready0", 64'(req_ready), 64'd1);
    expect_res(0, 64'd756);
    tick();
    #1;
    check("bp_ready1", 64'(req_ready), 64'd2);
    expect_res(1, 64'h0000_0001_0000_0000);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_ready", 64'(req_ready), 64'd0);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_y", out_y, 64'd756);
      check("stall_id", 64'(out_id), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    req_valid = 4'b0100;
    #1;
    check("bp_ready2", 64'(req_ready), 64'd4);
    expect_res(2, 64'hFE01_0000_0000_0000);
    tick();
    req_valid = '0;
    idle(4);

    // reset with two results in flight
    set_req(3, 32'h0000_003F, 32'h0000_0040);
    set_req(0, 32'h0000_00FF, 32'h0000_0003);
    req_valid = 4'b1001;
    idle(2);
    req_valid = '1;
    rst_n = 1'b0;
    #1;
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_y", out_y, 64'd0);
    check("flush_ready", 64'(req_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_ptr", 64'(req_ready), 64'd1);
    expect_res(0, 64'd756);
    tick();
    req_valid = '0;
    idle(4);

`ifdef APPROX_MUL_EXACT_EN
    req_exact = 4'b0110;
    issue_one(1, 32'h0000_00FF, 32'h0000_0003, 64'd765);
    issue_one(2, 32'h0000_0000, 32'hFFFF_FFFF, 64'd0);
    req_exact = '0;
    idle(4);
`endif

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("result_count", 64'(n_out), 64'(n_exp));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
